// File: rtl/key_event_display_pkg.sv
// -----------------------------------------------------------------------------
// key_event_display_pkg
// Shared definitions for the PS/2 key event display:
//   - kbd_state_e : scan-code decoder states
//   - PREFIX_EXT / PREFIX_BRK : E0 and F0 prefix bytes
//   - SEG_BLANK   : all segments off (active-low)
//   - hex_to_seg  : 4-bit value -> active-low 7-segment pattern (bit0=a..bit6=g)
// -----------------------------------------------------------------------------
package key_event_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_e;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/key_event_display_scan_to_ascii.sv
// -----------------------------------------------------------------------------
// scan_to_ascii
// Combinational PS/2 set-2 scan code to ASCII lookup (lowercase letters,
// digits 0-9 and space). Codes without a printable mapping report
// ascii_valid=0.
//   code        in  8  scan byte (without prefix)
//   ascii       out 8  ASCII character (8'h00 when unmapped)
//   ascii_valid out 1  a mapping exists for code
// -----------------------------------------------------------------------------
module scan_to_ascii (
    input  logic [7:0] code,
    output logic [7:0] ascii,
    output logic       ascii_valid
);

    // Lookup table; unmapped codes fall through to the default entry.
    always_comb begin
        ascii       = 8'h00;
        ascii_valid = 1'b1;
        case (code)
            8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;  8'h29: ascii = 8'h20;
            default: begin
                ascii       = 8'h00;
                ascii_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/key_event_display.sv
// -----------------------------------------------------------------------------
// key_event_display
// Decodes PS/2 scan bytes into make/break events, tracks the held key,
// counts distinct presses in BCD and drives a multi-digit 7-segment display.
//   clk, rst            clock, asynchronous active-high reset
//   code_valid, code    one-cycle strobe with scan byte
//   seg [7*NDIG-1:0]    active-low segments; digits 1:0 code hex,
//                       3:2 ASCII hex, NDIG-1:4 BCD press count
//   key_down            a make is held and not yet released
//   key_ext             held / last key carried an E0 prefix
//   cnt_wrap            one-cycle pulse when the press counter rolls over
// The incoming byte is captured in an input register and decoded on the
// following edge, so every output changes one edge after the sampling edge.
// -----------------------------------------------------------------------------
module key_event_display
    import key_event_display_pkg::*;
#(
    parameter  int CNT_DIGITS       = 2,
    parameter  int BLANK_ON_RELEASE = 1,
    localparam int NDIG             = 4 + CNT_DIGITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              code_valid,
    input  logic [7:0]        code,
    output logic [7*NDIG-1:0] seg,
    output logic              key_down,
    output logic              key_ext,
    output logic              cnt_wrap
);

    localparam int CW = 4 * CNT_DIGITS;

    logic              in_valid_q, in_valid_d;
    logic [7:0]        in_code_q, in_code_d;
    kbd_state_e        state_q, state_d;
    logic              key_down_q, key_down_d;
    logic              key_ext_q, key_ext_d;
    logic [7:0]        code_q, code_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cnt_wrap_q, cnt_wrap_d;
    logic [7*NDIG-1:0] seg_q, seg_d, seg_rst_s;

    logic              is_make_s, is_break_s, ev_ext_s, held_match_s;
    logic [CW-1:0]     cnt_inc_s;
    logic              cnt_carry_s;
    logic [7:0]        ascii_s;
    logic              ascii_valid_s;

    // ASCII lookup of the code that will be latched after this edge.
    scan_to_ascii u_ascii (
        .code        (code_d),
        .ascii       (ascii_s),
        .ascii_valid (ascii_valid_s)
    );

    // Input capture stage; the held byte only changes on a strobe.
    always_comb begin
        in_valid_d = code_valid;
        if (code_valid) begin
            in_code_d = code;
        end else begin
            in_code_d = in_code_q;
        end
    end

    // Prefix decoder: classifies the captured byte as prefix, make or break.
    always_comb begin
        state_d    = state_q;
        is_make_s  = 1'b0;
        is_break_s = 1'b0;
        ev_ext_s   = 1'b0;
        if (in_valid_q) begin
            if (in_code_q == PREFIX_EXT) begin
                // E0 always (re)starts an extended sequence.
                state_d = ST_EXT;
            end else if (in_code_q == PREFIX_BRK) begin
                // F0 continues an E0 sequence, otherwise restarts as plain break.
                state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
            end else begin
                state_d = ST_IDLE;
                case (state_q)
                    ST_IDLE:    is_make_s = 1'b1;
                    ST_EXT:     begin is_make_s = 1'b1;  ev_ext_s = 1'b1; end
                    ST_BRK:     is_break_s = 1'b1;
                    ST_EXT_BRK: begin is_break_s = 1'b1; ev_ext_s = 1'b1; end
                    default:    state_d = ST_IDLE;
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // BCD increment of the press counter, rippling carry through the digits.
    always_comb begin
        logic carry;
        logic [3:0] dig;
        cnt_inc_s = cnt_q;
        carry     = 1'b1;
        for (int i = 0; i < CNT_DIGITS; i++) begin
            dig = cnt_q[4*i +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    cnt_inc_s[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc_s[4*i +: 4] = dig + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                cnt_inc_s[4*i +: 4] = dig;
            end
        end
        cnt_carry_s = carry;
    end

    // Held-key tracking: new makes latch and count, repeats and foreign breaks are ignored.
    always_comb begin
        key_down_d   = key_down_q;
        key_ext_d    = key_ext_q;
        code_d       = code_q;
        cnt_d        = cnt_q;
        cnt_wrap_d   = 1'b0;
        held_match_s = key_down_q && ({ev_ext_s, in_code_q} == {key_ext_q, code_q});
        if (is_make_s && !held_match_s) begin
            key_down_d = 1'b1;
            key_ext_d  = ev_ext_s;
            code_d     = in_code_q;
            cnt_d      = cnt_inc_s;
            cnt_wrap_d = cnt_carry_s;
        end else if (is_break_s && held_match_s) begin
            key_down_d = 1'b0;
        end else begin
            key_down_d = key_down_q;
        end
    end

    // Display image built from next-state values so it lines up with key_down.
    always_comb begin
        seg_d = '0;
        seg_d[6:0]   = hex_to_seg(code_d[3:0]);
        seg_d[13:7]  = hex_to_seg(code_d[7:4]);
        if (ascii_valid_s && !key_ext_d) begin
            seg_d[20:14] = hex_to_seg(ascii_s[3:0]);
            seg_d[27:21] = hex_to_seg(ascii_s[7:4]);
        end else begin
            seg_d[20:14] = SEG_BLANK;
            seg_d[27:21] = SEG_BLANK;
        end
        if ((BLANK_ON_RELEASE != 0) && !key_down_d) begin
            seg_d[27:0] = {4{SEG_BLANK}};
        end else begin
            seg_d[27:0] = seg_d[27:0];
        end
        for (int k = 0; k < CNT_DIGITS; k++) begin
            seg_d[7*(4+k) +: 7] = hex_to_seg(cnt_d[4*k +: 4]);
        end
    end

    // Reset display image: code 00 (no ASCII mapping) and a zero count.
    always_comb begin
        seg_rst_s = '0;
        if (BLANK_ON_RELEASE != 0) begin
            seg_rst_s[27:0] = {4{SEG_BLANK}};
        end else begin
            seg_rst_s[27:0] = {SEG_BLANK, SEG_BLANK, hex_to_seg(4'h0), hex_to_seg(4'h0)};
        end
        for (int k = 0; k < CNT_DIGITS; k++) begin
            seg_rst_s[7*(4+k) +: 7] = hex_to_seg(4'h0);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_valid_q <= 1'b0;
            in_code_q  <= 8'h00;
            state_q    <= ST_IDLE;
            key_down_q <= 1'b0;
            key_ext_q  <= 1'b0;
            code_q     <= 8'h00;
            cnt_q      <= '0;
            cnt_wrap_q <= 1'b0;
            seg_q      <= seg_rst_s;
        end else begin
            in_valid_q <= in_valid_d;
            in_code_q  <= in_code_d;
            state_q    <= state_d;
            key_down_q <= key_down_d;
            key_ext_q  <= key_ext_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            cnt_wrap_q <= cnt_wrap_d;
            seg_q      <= seg_d;
        end
    end

    assign seg      = seg_q;
    assign key_down = key_down_q;
    assign key_ext  = key_ext_q;
    assign cnt_wrap = cnt_wrap_q;

endmodule

// File: tb/tb_key_event_display.sv
// -----------------------------------------------------------------------------
// tb_key_event_display
// Directed scenarios for key_event_display with default parameters
// (CNT_DIGITS=2, BLANK_ON_RELEASE=1, 6 digits). Expected segment images are
// hand-computed constants; digit order in the literals is {d5,d4,d3,d2,d1,d0}.
// -----------------------------------------------------------------------------
module tb_key_event_display;

    logic        clk;
    logic        rst;
    logic        code_valid;
    logic [7:0]  code;
    logic [41:0] seg;
    logic        key_down;
    logic        key_ext;
    logic        cnt_wrap;

    int errors = 0;
    int checks = 0;

    // count 0, digits 3:0 blank
    localparam logic [41:0] SEG_RESET   = {7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    // count 01, ASCII "61", code "1C"
    localparam logic [41:0] SEG_1C_C1   = {7'h40, 7'h79, 7'h02, 7'h79, 7'h79, 7'h46};
    // count 01, digits 3:0 blank
    localparam logic [41:0] SEG_REL_C1  = {7'h40, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    // count 01, ASCII blank, code "75"
    localparam logic [41:0] SEG_75X_C1  = {7'h40, 7'h79, 7'h7F, 7'h7F, 7'h78, 7'h12};
    // count 01, ASCII "62", code "32"
    localparam logic [41:0] SEG_32_C1   = {7'h40, 7'h79, 7'h02, 7'h24, 7'h30, 7'h24};

    key_event_display dut (
        .clk        (clk),
        .rst        (rst),
        .code_valid (code_valid),
        .code       (code),
        .seg        (seg),
        .key_down   (key_down),
        .key_ext    (key_ext),
        .cnt_wrap   (cnt_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        code_valid = 1'b0;
        code = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        code = b;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        code = 8'h00;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL reset_key_down got=%b exp=0", key_down); end
        checks++; if (key_ext !== 1'b0) begin errors++; $display("FAIL reset_key_ext got=%b exp=0", key_ext); end
        checks++; if (cnt_wrap !== 1'b0) begin errors++; $display("FAIL reset_cnt_wrap got=%b exp=0", cnt_wrap); end
        checks++; if (seg !== SEG_RESET) begin errors++; $display("FAIL reset_seg got=%h exp=%h", seg, SEG_RESET); end
    endtask

    task automatic test_press_release();
        apply_reset();
        send_byte(8'h1C);
        // one edge after the sampling edge nothing has changed yet
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL latency_early got=%b exp=0", key_down); end
        @(negedge clk);
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL latency_key_down got=%b exp=1", key_down); end
        checks++; if (seg !== SEG_1C_C1) begin errors++; $display("FAIL press_seg got=%h exp=%h", seg, SEG_1C_C1); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        settle();
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL release_key_down got=%b exp=0", key_down); end
        checks++; if (seg !== SEG_REL_C1) begin errors++; $display("FAIL release_seg got=%h exp=%h", seg, SEG_REL_C1); end
    endtask

    task automatic test_typematic();
        apply_reset();
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        settle();
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL typematic_key_down got=%b exp=1", key_down); end
        checks++; if (seg !== SEG_1C_C1) begin errors++; $display("FAIL typematic_seg got=%h exp=%h", seg, SEG_1C_C1); end
        // bytes without a strobe must be ignored
        @(negedge clk); code = 8'hF0;
        @(negedge clk); code = 8'h1C;
        @(negedge clk); code = 8'h00;
        settle();
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL no_strobe_key_down got=%b exp=1", key_down); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        settle();
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL typematic_release got=%b exp=0", key_down); end
        checks++; if (seg !== SEG_REL_C1) begin errors++; $display("FAIL typematic_count got=%h exp=%h", seg, SEG_REL_C1); end
    endtask

    task automatic test_extended();
        apply_reset();
        send_byte(8'hE0);
        send_byte(8'h75);
        settle();
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL ext_key_down got=%b exp=1", key_down); end
        checks++; if (key_ext !== 1'b1) begin errors++; $display("FAIL ext_key_ext got=%b exp=1", key_ext); end
        checks++; if (seg !== SEG_75X_C1) begin errors++; $display("FAIL ext_seg got=%h exp=%h", seg, SEG_75X_C1); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        settle();
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL ext_release got=%b exp=0", key_down); end
        checks++; if (key_ext !== 1'b1) begin errors++; $display("FAIL ext_key_ext_kept got=%b exp=1", key_ext); end
        checks++; if (seg !== SEG_REL_C1) begin errors++; $display("FAIL ext_release_seg got=%h exp=%h", seg, SEG_REL_C1); end
    endtask

    task automatic test_wrap();
        int pulses;
        apply_reset();
        pulses = 0;
        for (int i = 1; i <= 99; i++) begin
            send_byte((i % 2 == 1) ? 8'h1C : 8'h32);
            if (cnt_wrap === 1'b1) pulses++;
        end
        settle();
        checks++; if (seg[41:28] !== {7'h10, 7'h10}) begin errors++; $display("FAIL wrap_count99 got=%h exp=%h", seg[41:28], {7'h10, 7'h10}); end
        send_byte(8'h32);
        for (int j = 0; j < 4; j++) begin
            if (cnt_wrap === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL wrap_pulse_cycles got=%0d exp=1", pulses); end
        checks++; if (seg[41:28] !== {7'h40, 7'h40}) begin errors++; $display("FAIL wrap_count00 got=%h exp=%h", seg[41:28], {7'h40, 7'h40}); end
        checks++; if (cnt_wrap !== 1'b0) begin errors++; $display("FAIL wrap_pulse_end got=%b exp=0", cnt_wrap); end
    endtask

    task automatic test_unmatched_and_midreset();
        apply_reset();
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h32);
        settle();
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL unmatched_key_down got=%b exp=1", key_down); end
        checks++; if (seg !== SEG_1C_C1) begin errors++; $display("FAIL unmatched_seg got=%h exp=%h", seg, SEG_1C_C1); end
        send_byte(8'hE0);
        settle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL midrst_key_down got=%b exp=0", key_down); end
        checks++; if (key_ext !== 1'b0) begin errors++; $display("FAIL midrst_key_ext got=%b exp=0", key_ext); end
        checks++; if (seg !== SEG_RESET) begin errors++; $display("FAIL midrst_seg got=%h exp=%h", seg, SEG_RESET); end
        rst = 1'b0;
        send_byte(8'h1C);
        settle();
        checks++; if (key_ext !== 1'b0) begin errors++; $display("FAIL midrst_plain_ext got=%b exp=0", key_ext); end
        checks++; if (seg !== SEG_1C_C1) begin errors++; $display("FAIL midrst_plain_seg got=%h exp=%h", seg, SEG_1C_C1); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        @(negedge clk); code = 8'h1C; code_valid = 1'b1;
        @(negedge clk); code = 8'hF0;
        @(negedge clk); code = 8'h1C;
        @(negedge clk); code_valid = 1'b0; code = 8'h00;
        settle();
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL b2b_key_down got=%b exp=0", key_down); end
        checks++; if (seg !== SEG_REL_C1) begin errors++; $display("FAIL b2b_seg got=%h exp=%h", seg, SEG_REL_C1); end
        // a new key immediately after release counts again
        @(negedge clk); code = 8'h32; code_valid = 1'b1;
        @(negedge clk); code_valid = 1'b0; code = 8'h00;
        settle();
        checks++; if (seg[41:28] !== {7'h40, 7'h24}) begin errors++; $display("FAIL b2b_count2 got=%h exp=%h", seg[41:28], {7'h40, 7'h24}); end
        checks++; if (seg[27:0] !== SEG_32_C1[27:0]) begin errors++; $display("FAIL b2b_code32 got=%h exp=%h", seg[27:0], SEG_32_C1[27:0]); end
    endtask

    initial begin
        rst = 1'b1;
        code_valid = 1'b0;
        code = 8'h00;
        test_reset();
        test_press_release();
        test_typematic();
        test_extended();
        test_wrap();
        test_unmatched_and_midreset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_event_display.md
KEY_EVENT_DISPLAY -- requirements
Module: key_event_display

Interface
REQ-001 Parameter CNT_DIGITS, default 2, number of BCD press-counter digits (legal 1..4).
REQ-002 Parameter BLANK_ON_RELEASE, default 1, when 1 the code and ASCII digits blank while no key is held.
REQ-003 Parameter NDIG, default 4+CNT_DIGITS, total digit count; derived, not overridable.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 code_valid  in  1  one-cycle strobe marking a received PS/2 scan byte.
REQ-007 code  in  8  scan byte, sampled when code_valid=1.
REQ-008 seg  out  7*NDIG  active-low segments, digit k at [7k+6:7k], bit0=a..bit6=g.
REQ-009 key_down  out  1  a make code is held and not yet released.
REQ-010 key_ext  out  1  held or last key carried an E0 prefix.
REQ-011 cnt_wrap  out  1  one-cycle pulse when the press counter rolls over.

Function
REQ-012 The decoder FSM SHALL have states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 then F0 seen).
REQ-013 Transitions on code_valid: IDLE/E0->EXT, IDLE/F0->BRK, EXT/F0->EXT_BRK, and any other byte completes an event and returns to IDLE.
REQ-014 A make event (IDLE or EXT completing) whose {ext,code} differs from the held key, or arrives while key_down=0, SHALL latch {ext,code}, set key_down, and increment the counter.
REQ-015 A make event equal to the held key (typematic repeat) SHALL change nothing and SHALL NOT increment the counter.
REQ-016 A break event (BRK or EXT_BRK completing) matching the held {ext,code} SHALL clear key_down; a non-matching break SHALL be ignored.
REQ-017 The counter SHALL be CNT_DIGITS BCD digits, wrap from all-9s to 0, and assert cnt_wrap for exactly the wrap cycle.
REQ-018 Digits 1:0 SHALL show the latched code in hex, digits 3:2 the ASCII hex of the latched code, and digits NDIG-1:4 the BCD count.
REQ-019 Scan codes with no ASCII mapping, and all extended codes, SHALL display ASCII digits as blank (7'h7F).
REQ-020 With BLANK_ON_RELEASE=1 and key_down=0, digits 3:0 SHALL be 7'h7F; the count digits always show.
REQ-021 Hex encoding SHALL be 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex, active-low).
REQ-022 All outputs SHALL be registered; seg, key_down and key_ext update on the first clk edge after the edge sampling the completing byte (latency 1).
REQ-023 Bytes arriving without code_valid SHALL be ignored; back-to-back code_valid on consecutive cycles SHALL each be processed.
REQ-024 An E0 or F0 received in EXT/BRK/EXT_BRK other than EXT/F0 SHALL restart decoding as if received in IDLE.

Reset
REQ-025 On rst assertion: FSM=IDLE, key_down=0, key_ext=0, latched code=00, counter=0, cnt_wrap=0, seg=blank digits 3:0 (if BLANK_ON_RELEASE) else "00", count digits "0".
REQ-026 Reset mid-sequence (e.g. after E0) SHALL discard the prefix; the next byte is decoded from IDLE.

Structure
REQ-027 A shared package SHALL hold the FSM state typedef, prefix constants E0/F0, the hex-to-segment table and SEG_BLANK=7'h7F.
REQ-028 One sub-module scan_to_ascii (combinational 8-bit code -> 8-bit ASCII plus valid) SHALL be instantiated; hex-to-segment SHALL be a package function.

Verification
REQ-029 Reset, then 1C,F0,1C -> key_down 1 then 0, digits 1:0 "1C", digits 3:2 "61" while held, count 1, all of 3:0 blank after release.
REQ-030 1C,1C,1C,F0,1C -> count stays 1 (typematic), key_down cleared only by the break.
REQ-031 E0,75,E0,F0,75 -> key_ext=1, digits 1:0 "75", ASCII digits blank, count 1, key_down 0 at end.
REQ-032 100 distinct presses with CNT_DIGITS=2 -> count 99 then 00, cnt_wrap high exactly one cycle.
REQ-033 1C, F0,32 (unmatched break) -> key_down stays 1; then rst during E0 prefix -> all outputs at reset values, next 1C decoded as plain make.
REQ-034 Back-to-back code_valid on consecutive cycles 1C,F0,1C -> identical final state to spaced stimulus.
